// File: rtl/m_lsu.sv
// rtl/m_lsu.sv - M-stage load/store initiator on a valid/ready word bus.
// `define LSU_ALIGN_CHECK_EN to trap misaligned word/half accesses.

module m_lsu #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wd,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

   localparam logic [2:0] DM_W  = 3'd0;
   localparam logic [2:0] DM_H  = 3'd1;
   localparam logic [2:0] DM_HU = 3'd2;
   localparam logic [2:0] DM_B  = 3'd3;
   localparam logic [2:0] DM_BU = 3'd4;
   localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [2:0]  type_q;
   logic [1:0]  alo_q;
   logic [31:0] unused_pc_q;
   logic        done_q;
   logic        err_q;
   logic [31:0] rdata_q;
   logic        bus_valid_q;
   logic        bus_we_q;
   logic [31:0] bus_addr_q;
   logic [3:0]  bus_be_q;
   logic [31:0] bus_wdata_q;

   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic        bad_d;
   logic [15:0] half_d;
   logic [7:0]  byte_sel_d;
   logic [31:0] load_d;

   assign stall     = req_valid && (state_q != S_DONE);
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign bus_valid = bus_valid_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;

   // Lane steering for the incoming request; loads reuse the same byte enables.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = req_wd;
      bad_d   = 1'b0;
      case (req_type)
         DM_W: be_d = 4'b1111;
         DM_H, DM_HU: begin
            be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{req_wd[15:0]}};
         end
         DM_B, DM_BU: begin
            be_d    = 4'b0001 << req_addr[1:0];
            wdata_d = {4{req_wd[7:0]}};
         end
         default: bad_d = 1'b1;
      endcase
`ifdef LSU_ALIGN_CHECK_EN
      if ((req_type == DM_W) && (req_addr[1:0] != 2'b00))
         bad_d = 1'b1;
      if (((req_type == DM_H) || (req_type == DM_HU)) && req_addr[0])
         bad_d = 1'b1;
`endif
   end

   always_comb begin
      half_d = alo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (alo_q)
         2'd0:    byte_sel_d = bus_rdata[7:0];
         2'd1:    byte_sel_d = bus_rdata[15:8];
         2'd2:    byte_sel_d = bus_rdata[23:16];
         default: byte_sel_d = bus_rdata[31:24];
      endcase
      case (type_q)
         DM_H:    load_d = {{16{half_d[15]}}, half_d};
         DM_HU:   load_d = {16'h0000, half_d};
         DM_B:    load_d = {{24{byte_sel_d[7]}}, byte_sel_d};
         DM_BU:   load_d = {24'h000000, byte_sel_d};
         default: load_d = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         type_q      <= 3'd0;
         alo_q       <= 2'd0;
         unused_pc_q <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= 32'd0;
         bus_valid_q <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_be_q    <= 4'd0;
         bus_wdata_q <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  type_q      <= req_type;
                  alo_q       <= req_addr[1:0];
                  unused_pc_q <= pc;
                  cnt_q       <= 8'd0;
                  if (bad_d) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                     rdata_q <= 32'd0;
                  end else begin
                     state_q     <= S_REQ;
                     bus_valid_q <= 1'b1;
                     bus_we_q    <= req_we;
                     bus_addr_q  <= {req_addr[31:2], 2'b00};
                     bus_be_q    <= be_d;
                     bus_wdata_q <= wdata_d;
                  end
               end
            end
            S_REQ: begin
               if (bus_ready) begin
                  bus_valid_q <= 1'b0;
                  bus_we_q    <= 1'b0;
                  cnt_q       <= 8'd0;
                  if (bus_we_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     rdata_q <= 32'd0;
                  end else begin
                     state_q <= S_RESP;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  bus_valid_q <= 1'b0;
                  bus_we_q    <= 1'b0;
                  state_q     <= S_DONE;
                  done_q      <= 1'b1;
                  err_q       <= 1'b1;
                  rdata_q     <= 32'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_RESP: begin
               if (bus_rvalid) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  rdata_q <= load_d;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  rdata_q <= 32'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_DONE: begin
               // Pipeline advances on this edge; any new request is seen from IDLE.
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= 32'd0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m_lsu.sv
// tb/tb_m_lsu.sv - randomized self-checking bench for m_lsu against a behavioural model.

module tb_m_lsu;

   localparam int W = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = 32'd0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_type = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wd = 32'd0;
   logic        stall, done, err;
   logic [31:0] rdata;
   logic        bus_valid;
   logic        bus_ready = 1'b0;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'd0;

   int n_cmp = 0;
   int n_bad = 0;

   // observations recorded by run_txn
   int          o_done_cyc;
   logic        o_err, o_saw_valid, o_saw_write, o_unstable, o_stall_bad, o_post_active, o_valid_at_done;
   logic [31:0] o_rdata, o_addr, o_wdata;
   logic [3:0]  o_be;
   logic        o_we;

   // expectations produced by model_expect
   int          e_done_cyc;
   logic        e_err, e_bus;
   logic [31:0] e_rdata, e_addr, e_wdata;
   logic [3:0]  e_be;

   m_lsu #(.WAIT_MAX(W)) dut (
      .clk(clk), .reset(reset), .pc(pc),
      .req_valid(req_valid), .req_we(req_we), .req_type(req_type),
      .req_addr(req_addr), .req_wd(req_wd),
      .stall(stall), .done(done), .err(err), .rdata(rdata),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   function automatic int model_size(input logic [2:0] t);
      if (t == 3'd0) return 4;
      if (t == 3'd1 || t == 3'd2) return 2;
      return 1;
   endfunction

   function automatic int model_off(input logic [2:0] t, input logic [31:0] a);
      if (t == 3'd0) return 0;
      if (t == 3'd1 || t == 3'd2) return a[1] ? 2 : 0;
      return int'(a[1:0]);
   endfunction

   task automatic model_expect(input logic we, input logic [2:0] t, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] rword,
                               input int rd, input int vd);
      int size, off;
      longint unsigned v, mask;
      logic bad;
      size = model_size(t);
      off  = model_off(t, a);
      bad  = (t > 3'd4);
`ifdef LSU_ALIGN_CHECK_EN
      if (t == 3'd0 && a[1:0] != 2'b00) bad = 1'b1;
      if ((t == 3'd1 || t == 3'd2) && a[0]) bad = 1'b1;
`endif
      e_addr = {a[31:2], 2'b00};
      for (int i = 0; i < 4; i++) begin
         e_be[i] = (i >= off) && (i < off + size);
         e_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      end
      mask = (64'd1 << (8 * size)) - 64'd1;
      v = (longint'(rword) >> (8 * off)) & mask;
      if ((t == 3'd1 || t == 3'd3) && (((v >> (8 * size - 1)) & 64'd1) == 64'd1))
         v = v | ~mask;
      e_rdata = 32'd0;
      e_err = 1'b0;
      e_bus = 1'b1;
      if (bad) begin
         e_done_cyc = 1; e_err = 1'b1; e_bus = 1'b0;
      end else if (rd >= W) begin
         e_done_cyc = 1 + W; e_err = 1'b1;
      end else if (we) begin
         e_done_cyc = 2 + rd;
      end else if (vd >= W) begin
         e_done_cyc = 2 + rd + W; e_err = 1'b1;
      end else begin
         e_done_cyc = 3 + rd + vd; e_rdata = v[31:0];
      end
   endtask

   // Drives one request and plays the bus slave: ready after rd refused valid cycles,
   // rvalid after vd idle response cycles. Cycle 0 is the IDLE cycle that sees req_valid.
   task automatic run_txn(input logic we, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rword,
                          input int rd, input int vd);
      int vcount, acc;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wd = wd;
      pc = $urandom;
      o_done_cyc = -1; o_err = 1'b0; o_rdata = 32'd0; o_saw_valid = 1'b0; o_saw_write = 1'b0;
      o_unstable = 1'b0; o_stall_bad = 1'b0; o_valid_at_done = 1'b0;
      o_addr = 32'd0; o_be = 4'd0; o_wdata = 32'd0; o_we = 1'b0;
      acc = -1; vcount = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (done) begin
            o_done_cyc = c; o_err = err; o_rdata = rdata; o_valid_at_done = bus_valid;
            if (stall !== 1'b0) o_stall_bad = 1'b1;
            break;
         end
         if (stall !== 1'b1) o_stall_bad = 1'b1;
         if (bus_valid) begin
            vcount++;
            if (!o_saw_valid) begin
               o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata; o_we = bus_we;
            end else if (bus_addr !== o_addr || bus_be !== o_be || bus_wdata !== o_wdata || bus_we !== o_we) begin
               o_unstable = 1'b1;
            end
            o_saw_valid = 1'b1;
            if (bus_we) o_saw_write = 1'b1;
            bus_ready = (vcount > rd);
            if (bus_ready) acc = c;
         end else begin
            bus_ready = 1'b0;
         end
         if (acc >= 0 && c > acc && !we) begin
            bus_rvalid = ((c - acc - 1) >= vd);
            bus_rdata  = bus_rvalid ? rword : $urandom;
         end else begin
            bus_rvalid = 1'b0;
            bus_rdata  = $urandom;
         end
         @(negedge clk);
      end
      req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
      @(negedge clk);
      #1;
      o_post_active = done | err | bus_valid;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_done_err got %b%b want 00", done, err); end
      n_cmp++; if (bus_valid !== 1'b0 || bus_we !== 1'b0) begin n_bad++; $display("FAIL reset_bus_ctl got %b%b want 00", bus_valid, bus_we); end
      n_cmp++; if (bus_addr !== 32'd0 || bus_be !== 4'd0 || bus_wdata !== 32'd0 || rdata !== 32'd0)
         begin n_bad++; $display("FAIL reset_data got %h %h %h %h want zeros", bus_addr, bus_be, bus_wdata, rdata); end
      req_valid = 1'b1;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall_follow got %b want 1", stall); end
      req_valid = 1'b0;
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall_low got %b want 0", stall); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_store_word();
      run_txn(1'b1, 3'd0, 32'h0000_0010, 32'hDEADBEEF, 32'h0, 0, 0);
      n_cmp++; if (o_done_cyc !== 2) begin n_bad++; $display("FAIL sw_done_cycle got %0d want 2", o_done_cyc); end
      n_cmp++; if (o_addr !== 32'h10 || o_be !== 4'b1111 || o_wdata !== 32'hDEADBEEF || o_we !== 1'b1)
         begin n_bad++; $display("FAIL sw_bus got %h %b %h %b want 00000010 1111 deadbeef 1", o_addr, o_be, o_wdata, o_we); end
      n_cmp++; if (o_stall_bad !== 1'b0 || o_err !== 1'b0) begin n_bad++; $display("FAIL sw_stall_err got %b %b want 0 0", o_stall_bad, o_err); end
      n_cmp++; if (o_post_active !== 1'b0) begin n_bad++; $display("FAIL sw_done_pulse got %b want 0", o_post_active); end
   endtask

   task automatic test_load_byte();
      run_txn(1'b0, 3'd3, 32'h13, 32'h0, 32'h80112233, 0, 0);
      n_cmp++; if (o_rdata !== 32'hFFFFFF80 || o_done_cyc !== 3) begin n_bad++; $display("FAIL lb_rdata got %h @%0d want ffffff80 @3", o_rdata, o_done_cyc); end
      n_cmp++; if (o_be !== 4'b1000 || o_we !== 1'b0) begin n_bad++; $display("FAIL lb_be got %b %b want 1000 0", o_be, o_we); end
      run_txn(1'b0, 3'd4, 32'h13, 32'h0, 32'h80112233, 0, 0);
      n_cmp++; if (o_rdata !== 32'h00000080) begin n_bad++; $display("FAIL lbu_rdata got %h want 00000080", o_rdata); end
   endtask

   task automatic test_load_half_wait();
      run_txn(1'b0, 3'd1, 32'h2, 32'h0, 32'h8001_7FFF, 3, 0);
      n_cmp++; if (o_rdata !== 32'hFFFF8001) begin n_bad++; $display("FAIL lh_rdata got %h want ffff8001", o_rdata); end
      n_cmp++; if (o_done_cyc !== 6) begin n_bad++; $display("FAIL lh_done_cycle got %0d want 6", o_done_cyc); end
      n_cmp++; if (o_unstable !== 1'b0 || o_be !== 4'b1100) begin n_bad++; $display("FAIL lh_stable got %b be %b want 0 1100", o_unstable, o_be); end
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 3'd0, 32'h40, 32'h0, 32'h0, 100, 0);
      n_cmp++; if (o_done_cyc !== 1 + W || o_err !== 1'b1) begin n_bad++; $display("FAIL to_done got @%0d err %b want @%0d err 1", o_done_cyc, o_err, 1 + W); end
      n_cmp++; if (o_rdata !== 32'd0 || o_valid_at_done !== 1'b0 || o_post_active !== 1'b0)
         begin n_bad++; $display("FAIL to_quiet got %h %b %b want 0 0 0", o_rdata, o_valid_at_done, o_post_active); end
   endtask

   task automatic test_late_rvalid();
      run_txn(1'b0, 3'd0, 32'h80, 32'h0, 32'h1234_5678, 0, 10);
      n_cmp++; if (o_done_cyc !== 2 + W || o_err !== 1'b1 || o_rdata !== 32'd0)
         begin n_bad++; $display("FAIL resp_to got @%0d err %b rd %h want @%0d 1 0", o_done_cyc, o_err, o_rdata, 2 + W); end
      bus_rvalid = 1'b1; bus_rdata = $urandom;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_cmp++; if (done !== 1'b0 || bus_valid !== 1'b0) begin n_bad++; $display("FAIL late_rvalid got done %b valid %b want 0 0", done, bus_valid); end
      end
      bus_rvalid = 1'b0;
   endtask

   task automatic test_misaligned();
      run_txn(1'b1, 3'd0, 32'h6, 32'hCAFE_F00D, 32'h0, 0, 0);
`ifdef LSU_ALIGN_CHECK_EN
      n_cmp++; if (o_done_cyc !== 1 || o_err !== 1'b1 || o_saw_valid !== 1'b0)
         begin n_bad++; $display("FAIL misalign_err got @%0d err %b valid %b want @1 1 0", o_done_cyc, o_err, o_saw_valid); end
`else
      n_cmp++; if (o_done_cyc !== 2 || o_err !== 1'b0 || o_addr !== 32'h4 || o_be !== 4'b1111)
         begin n_bad++; $display("FAIL misalign_ok got @%0d err %b %h %b want @2 0 00000004 1111", o_done_cyc, o_err, o_addr, o_be); end
`endif
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_type = 3'd0; req_addr = 32'h8; req_wd = 32'h0;
      @(negedge clk); #1;
      n_cmp++; if (bus_valid !== 1'b1 || bus_addr !== 32'h8) begin n_bad++; $display("FAIL mid_req got %b %h want 1 00000008", bus_valid, bus_addr); end
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      reset = 1'b1;
      #1;
      n_cmp++; if (bus_valid !== 1'b0 || bus_addr !== 32'd0 || bus_be !== 4'd0 || done !== 1'b0 || rdata !== 32'd0)
         begin n_bad++; $display("FAIL mid_reset got %b %h %b %b %h want zeros", bus_valid, bus_addr, bus_be, done, rdata); end
      n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mid_reset_stall got %b want 1", stall); end
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL mid_no_done got %b %b want 0 0", done, err); end
      end
      bus_rvalid = 1'b0;
      run_txn(1'b1, 3'd6, 32'h100, 32'h5555_AAAA, 32'h0, 0, 0);
      n_cmp++; if (o_done_cyc !== 1 || o_err !== 1'b1 || o_saw_valid !== 1'b0 || o_saw_write !== 1'b0)
         begin n_bad++; $display("FAIL bad_type got @%0d err %b valid %b want @1 1 0", o_done_cyc, o_err, o_saw_valid); end
   endtask

   task automatic test_random();
      logic we;
      logic [2:0] t;
      logic [31:0] a, wd, rw;
      int rd, vd;
      for (int n = 0; n < 60; n++) begin
         we = 1'($urandom_range(0, 1));
         t  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         a  = $urandom; wd = $urandom; rw = $urandom;
         rd = $urandom_range(0, 5); vd = $urandom_range(0, 5);
         model_expect(we, t, a, wd, rw, rd, vd);
         run_txn(we, t, a, wd, rw, rd, vd);
         n_cmp++; if (o_done_cyc !== e_done_cyc || o_err !== e_err)
            begin n_bad++; $display("FAIL rnd%0d_done got @%0d err %b want @%0d err %b", n, o_done_cyc, o_err, e_done_cyc, e_err); end
         n_cmp++; if (o_rdata !== e_rdata) begin n_bad++; $display("FAIL rnd%0d_rdata got %h want %h", n, o_rdata, e_rdata); end
         n_cmp++; if (o_stall_bad !== 1'b0 || o_post_active !== 1'b0)
            begin n_bad++; $display("FAIL rnd%0d_handshake got stall_bad %b post %b want 0 0", n, o_stall_bad, o_post_active); end
         if (e_bus) begin
            n_cmp++; if (o_addr !== e_addr || o_be !== e_be || o_wdata !== e_wdata || o_we !== we || o_unstable !== 1'b0)
               begin n_bad++; $display("FAIL rnd%0d_bus got %h %b %h %b want %h %b %h %b", n, o_addr, o_be, o_wdata, o_we, e_addr, e_be, e_wdata, we); end
         end else begin
            n_cmp++; if (o_saw_valid !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_nobus got %b want 0", n, o_saw_valid); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_load_byte();
      test_load_half_wait();
      test_timeout();
      test_late_rvalid();
      test_misaligned();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/m_lsu.md
# m_lsu

Load/store initiator for the M stage. It takes the memory operation presented by the pipeline (type, address, store data) and drives it onto a word-wide valid/ready memory bus as a single transaction. It stalls the pipeline until the access finishes, then returns sign- or zero-extended load data. It also flags bad types, misaligned accesses and bus timeouts.

## Interface
Parameters:
- WAIT_MAX, default 255: cycles allowed in REQ or RESP before a timeout error; range 1..255, counter is 8 bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc  in  32  PC of the M-stage instruction; debug only, latched with the request.
- req_valid  in  1  M stage holds a load/store; inputs held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  `DM_w=0, `DM_h=1, `DM_hu=2, `DM_b=3, `DM_bu=4; 5..7 invalid.
- req_addr  in  32  byte address.
- req_wd  in  32  store data, right-aligned.
- stall  out  1  freeze the pipeline.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse, coincident with done.
- rdata  out  32  extended load data; valid while done=1.
- bus_valid  out  1  request valid.
- bus_ready  in  1  request accepted at a posedge where valid && ready.
- bus_we  out  1  write request.
- bus_addr  out  32  word address: {addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rvalid  in  1  read data valid; sampled only in RESP.
- bus_rdata  in  32  read word.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE, req_valid=0: stay in IDLE.
- IDLE, req_valid=1: latch the request.
  - Invalid type goes to DONE with err=1.
  - If the alignment check (see Configuration) fails, go to DONE with err=1.
  - Otherwise go to REQ.
- REQ: bus_valid=1; address, be, we and wdata come from latched values and stay stable.
  - On acceptance, a store goes to DONE and a load goes to RESP.
- RESP: on bus_rvalid, latch the extracted data and go to DONE.
- DONE: done=1 and stall=0, so the pipeline advances this edge; next state is IDLE.
  - req_valid is ignored in DONE.
- stall = req_valid && state!=DONE, combinational.
- Byte enables and store data:
  - w: be=1111, wdata=WD.
  - h: be=0011<<(2*addr[1]), wdata={2{WD[15:0]}}.
  - b: be=0001<<addr[1:0], wdata={4{WD[7:0]}}.
  - Loads drive the same be pattern.
- Load extraction:
  - w: whole word.
  - h/hu: half selected by addr[1], sign- or zero-extended to 32 bits.
  - b/bu: byte selected by addr[1:0], sign- or zero-extended.
- Timeout: an 8-bit counter clears on entering REQ or RESP.
  - When it reaches WAIT_MAX without progress: go to DONE with err=1, drop bus_valid, rdata=0.
  - A late bus_rvalid arriving in IDLE is ignored.
- Any error path: rdata=0 and no bus write occurs.

## Timing
- Reset values: state=IDLE; bus_valid, bus_we, done, err = 0; bus_addr, bus_be, bus_wdata, rdata = 0; counter = 0.
- stall follows req_valid combinationally, including during reset.
- All outputs except stall are registered from state and latched data.
- Store with ready held high: cycle0 IDLE (stall), cycle1 REQ (accept), cycle2 DONE. Three cycles, two of them stalled.
- Load with ready high and rvalid in the cycle after acceptance: DONE in cycle3.
- Error detected in IDLE: DONE in cycle1, with no bus activity.
- Reset asserted mid-transaction: bus_valid drops at once; no done pulse for the aborted access.

## Configuration
- LSU_ALIGN_CHECK_EN defined:
  - A word access with addr[1:0]!=0 is an error.
  - A half access with addr[0]!=0 is an error.
  - Either goes IDLE to DONE with err=1 and no bus transaction.
- Undefined:
  - No alignment error; the low bits are ignored.
  - w uses addr[31:2]; h uses addr[1], so addr[0] is dropped.
- Invalid-type and timeout errors apply in both builds.

## Test plan
- Store word: addr 0x0000_0010, WD 0xDEADBEEF, ready=1 → bus_addr 0x10, be 1111, wdata 0xDEADBEEF, done at cycle2, stall high in cycles 0–1.
- Load byte: addr 0x13, bus_rdata 0x80112233, rvalid one cycle after acceptance → b gives rdata 0xFFFFFF80; bu gives 0x00000080; be 1000.
- Load half with 3 cycles of bus_ready=0: addr 0x2, rdata 0x8001_7FFF → bus_valid held with stable fields; h gives rdata 0xFFFF8001, done exactly 1 cycle after RESP.
- Timeout: WAIT_MAX=4, bus_ready stuck at 0 → DONE 4 cycles after entering REQ with err=1, rdata=0, bus_valid=0 afterwards.
- Misaligned store word at addr 0x6:
  - with LSU_ALIGN_CHECK_EN: err=1 at cycle1, bus_valid never asserts.
  - without: bus_addr 0x4, be 1111.
- Reset asserted during RESP → all outputs zero immediately; the next request starts cleanly from IDLE; req_type 6 → err with no bus transaction.
